// File: rtl/ssit_mp.sv
// ---------------------------------------------------------------------------
// ssit_mp : store set ID table (SSIT) for memory dependence prediction
//
// The rename stage looks up an SSID and a valid bit for each of NUM_RD PC
// indices. The lookups are combinational and read the array directly.
// A load/store violation pair is accepted through a valid/ready handshake.
// The pair is applied in two stages:
//   - IDLE  : capture both indices, SSIDs and valid bits.
//   - MERGE : write the merged store set.
// A sweep walks the table and clears CLEAR_PER_CYCLE valid bits per cycle,
// so that stale store sets age out.
//
// Optional feature macro: SSIT_CYCLIC_CLEAR_EN
//   When defined, a free-running period counter requests a sweep every
//   CLEAR_PERIOD cycles. When undefined, only flush_in starts a sweep.
//
// Ports:
//   clock              rising-edge clock
//   reset              asynchronous, active-high reset
//   rd_index_in        NUM_RD packed lookup indices (port k at k*INDEX_W)
//   rd_ssid_out        NUM_RD packed SSIDs, same packing
//   rd_valid_out       per-port entry valid bit
//   update_v_in        violation pair offered
//   update_ready_out   pair is accepted when update_v_in is also high
//   update_ld_index_in load PC index of the pair
//   update_st_index_in store PC index of the pair
//   flush_in           request a full sweep (held until the sweep starts)
//   busy_out           sweep in progress
//   next_ssid_out      next SSID to be allocated
// ---------------------------------------------------------------------------
module ssit_mp #(
  parameter int SSIT_DEPTH      = 4096,
  parameter int INDEX_W         = 12,
  parameter int SSID_W          = 7,
  parameter int NUM_RD          = 4,
  parameter int CLEAR_PERIOD    = 65536,
  parameter int CLEAR_PER_CYCLE = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_RD*INDEX_W-1:0] rd_index_in,
  output logic [NUM_RD*SSID_W-1:0]  rd_ssid_out,
  output logic [NUM_RD-1:0]         rd_valid_out,
  input  logic                      update_v_in,
  output logic                      update_ready_out,
  input  logic [INDEX_W-1:0]        update_ld_index_in,
  input  logic [INDEX_W-1:0]        update_st_index_in,
  input  logic                      flush_in,
  output logic                      busy_out,
  output logic [SSID_W-1:0]         next_ssid_out
);

  typedef enum logic [1:0] {IDLE, MERGE, SWEEP} state_t;

  // The sweep pointer holds this value during the final sweep cycle.
  localparam logic [INDEX_W-1:0] SWEEP_LAST = INDEX_W'(SSIT_DEPTH - CLEAR_PER_CYCLE);

  state_t state, state_n;

  logic [SSID_W-1:0]     ssid_mem [SSIT_DEPTH];
  logic [SSIT_DEPTH-1:0] valid_mem;

  logic [INDEX_W-1:0] cap_ld_index, cap_st_index;
  logic [SSID_W-1:0]  cap_ld_ssid, cap_st_ssid;
  logic               cap_ld_v, cap_st_v;
  logic [INDEX_W-1:0] sweep_ptr;
  logic [SSID_W-1:0]  next_ssid;
  logic               flush_pend;
  logic               timer_pend;
  logic               sweep_req;
  logic               accept;
  logic               start_sweep;

  // Lookup ports read the array directly. An update that is still in
  // flight is not visible until its MERGE write has landed.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [INDEX_W-1:0] idx;
    assign idx = rd_index_in[k*INDEX_W +: INDEX_W];
    assign rd_ssid_out[k*SSID_W +: SSID_W] = ssid_mem[idx];
    assign rd_valid_out[k] = valid_mem[idx];
  end

  // A pending sweep blocks new updates, so the sweep always wins a tie.
  assign sweep_req        = flush_in | flush_pend | timer_pend;
  assign update_ready_out = (state == IDLE) && !sweep_req;
  assign accept           = update_v_in && update_ready_out;
  assign start_sweep      = (state == IDLE) && !accept && sweep_req;
  assign busy_out         = (state == SWEEP);
  assign next_ssid_out    = next_ssid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept)         state_n = MERGE;
        else if (sweep_req) state_n = SWEEP;
      end
      MERGE: state_n = IDLE;
      SWEEP: if (sweep_ptr == SWEEP_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Capture registers, sweep pointer, allocator and the sticky flush flag.
  // A flush seen while a sweep is starting or running is absorbed by that
  // sweep, so the flag only arms in IDLE (without starting) or in MERGE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_ld_index <= '0;
      cap_st_index <= '0;
      cap_ld_ssid  <= '0;
      cap_st_ssid  <= '0;
      cap_ld_v     <= 1'b0;
      cap_st_v     <= 1'b0;
      sweep_ptr    <= '0;
      next_ssid    <= '0;
      flush_pend   <= 1'b0;
    end else begin
      if (accept) begin
        cap_ld_index <= update_ld_index_in;
        cap_st_index <= update_st_index_in;
        cap_ld_ssid  <= ssid_mem[update_ld_index_in];
        cap_st_ssid  <= ssid_mem[update_st_index_in];
        cap_ld_v     <= valid_mem[update_ld_index_in];
        cap_st_v     <= valid_mem[update_st_index_in];
      end
      if (state == MERGE && !cap_ld_v && !cap_st_v)
        next_ssid <= next_ssid + 1'b1;
      if (state == SWEEP)
        sweep_ptr <= sweep_ptr + INDEX_W'(CLEAR_PER_CYCLE);
      if (start_sweep || state == SWEEP) flush_pend <= 1'b0;
      else if (flush_in)                 flush_pend <= 1'b1;
    end
  end

  // Table writes: the merged store set in MERGE, and a block of valid
  // clears in SWEEP. The pointer wraps to 0 on its own after the last block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_mem <= '0;
      for (int i = 0; i < SSIT_DEPTH; i++) ssid_mem[i] <= '0;
    end else begin
      if (state == MERGE) begin
        case ({cap_ld_v, cap_st_v})
          2'b00: begin
            ssid_mem[cap_ld_index]  <= next_ssid;
            ssid_mem[cap_st_index]  <= next_ssid;
            valid_mem[cap_ld_index] <= 1'b1;
            valid_mem[cap_st_index] <= 1'b1;
          end
          2'b01: begin
            ssid_mem[cap_ld_index]  <= cap_st_ssid;
            valid_mem[cap_ld_index] <= 1'b1;
          end
          2'b10: begin
            ssid_mem[cap_st_index]  <= cap_ld_ssid;
            valid_mem[cap_st_index] <= 1'b1;
          end
          default: begin
            if (cap_ld_ssid > cap_st_ssid)      ssid_mem[cap_ld_index] <= cap_st_ssid;
            else if (cap_st_ssid > cap_ld_ssid) ssid_mem[cap_st_index] <= cap_ld_ssid;
          end
        endcase
      end
      if (state == SWEEP) begin
        for (int j = 0; j < CLEAR_PER_CYCLE; j++)
          valid_mem[sweep_ptr + INDEX_W'(j)] <= 1'b0;
      end
    end
  end

`ifdef SSIT_CYCLIC_CLEAR_EN
  localparam int CNT_W = $clog2(CLEAR_PERIOD);

  logic [CNT_W-1:0] period_cnt;
  logic             period_expire;

  assign period_expire = (period_cnt == CNT_W'(CLEAR_PERIOD - 1));

  // The period counter runs in every state. An expiry that lands while a
  // sweep is starting or running is absorbed by that sweep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
      timer_pend <= 1'b0;
    end else begin
      if (period_expire) period_cnt <= '0;
      else               period_cnt <= period_cnt + 1'b1;
      if (start_sweep || state == SWEEP) timer_pend <= 1'b0;
      else if (period_expire)            timer_pend <= 1'b1;
    end
  end
`else
  assign timer_pend = 1'b0;
`endif

endmodule

// File: tb/tb_ssit_mp.sv
// ---------------------------------------------------------------------------
// tb_ssit_mp : directed, table-driven bench for ssit_mp
// Uses the default geometry (4096 entries, 64 cleared per sweep cycle,
// 7-bit SSIDs). CLEAR_PERIOD is 256.
// ---------------------------------------------------------------------------
module tb_ssit_mp;

  localparam int DEPTH  = 4096;
  localparam int IW     = 12;
  localparam int SW     = 7;
  localparam int NRD    = 4;
  localparam int PERIOD = 256;
  localparam int CPC    = 64;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NRD*IW-1:0] rd_index_in = '0;
  logic [NRD*SW-1:0] rd_ssid_out;
  logic [NRD-1:0]    rd_valid_out;
  logic              update_v_in = 1'b0;
  logic              update_ready_out;
  logic [IW-1:0]     update_ld_index_in = '0;
  logic [IW-1:0]     update_st_index_in = '0;
  logic              flush_in = 1'b0;
  logic              busy_out;
  logic [SW-1:0]     next_ssid_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [IW-1:0] ld;
    logic [IW-1:0] st;
    logic [SW-1:0] exp_ld;
    logic [SW-1:0] exp_st;
    logic [SW-1:0] exp_next;
  } vec_t;

  vec_t vecs[11];

  ssit_mp #(
    .SSIT_DEPTH(DEPTH), .INDEX_W(IW), .SSID_W(SW), .NUM_RD(NRD),
    .CLEAR_PERIOD(PERIOD), .CLEAR_PER_CYCLE(CPC)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_index_in(rd_index_in), .rd_ssid_out(rd_ssid_out), .rd_valid_out(rd_valid_out),
    .update_v_in(update_v_in), .update_ready_out(update_ready_out),
    .update_ld_index_in(update_ld_index_in), .update_st_index_in(update_st_index_in),
    .flush_in(flush_in), .busy_out(busy_out), .next_ssid_out(next_ssid_out)
  );

  always #5 clock = ~clock;

  // Cycles since reset release; the DUT period counter tracks the same count.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic setPort(input int k, input logic [IW-1:0] idx);
    rd_index_in[k*IW +: IW] = idx;
  endtask

  function automatic int portSsid(input int k);
    return int'(rd_ssid_out[k*SW +: SW]);
  endfunction

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    update_v_in = 1'b0;
    flush_in = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Offer one pair for one cycle. Ready must be high when the pair is
  // offered and low for the single MERGE cycle. The entries are then
  // sampled after the write edge through ports 0 and 1.
  task automatic applyStimulus(input logic [IW-1:0] ld, input logic [IW-1:0] st);
    @(negedge clock);
    update_ld_index_in = ld;
    update_st_index_in = st;
    update_v_in = 1'b1;
    setPort(0, ld);
    setPort(1, st);
    #1 checkVal("ready_offer", int'(update_ready_out), 1);
    @(posedge clock);
    #1 update_v_in = 1'b0;
    checkVal("ready_merge", int'(update_ready_out), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    checkVal({name, "_ld_ssid"}, portSsid(0), int'(v.exp_ld));
    checkVal({name, "_st_ssid"}, portSsid(1), int'(v.exp_st));
    checkVal({name, "_ld_valid"}, int'(rd_valid_out[0]), 1);
    checkVal({name, "_st_valid"}, int'(rd_valid_out[1]), 1);
    checkVal({name, "_next"}, int'(next_ssid_out), int'(v.exp_next));
    checkVal({name, "_ready"}, int'(update_ready_out), 1);
  endtask

  initial begin
    int busy_cnt;

    vecs[0]  = '{ld: 12'd20, st: 12'd21, exp_ld: 7'd0, exp_st: 7'd0, exp_next: 7'd1};
    vecs[1]  = '{ld: 12'd30, st: 12'd31, exp_ld: 7'd1, exp_st: 7'd1, exp_next: 7'd2};
    vecs[2]  = '{ld: 12'd40, st: 12'd41, exp_ld: 7'd2, exp_st: 7'd2, exp_next: 7'd3};
    vecs[3]  = '{ld: 12'd10, st: 12'd11, exp_ld: 7'd3, exp_st: 7'd3, exp_next: 7'd4};
    vecs[4]  = '{ld: 12'd10, st: 12'd30, exp_ld: 7'd1, exp_st: 7'd1, exp_next: 7'd4};
    vecs[5]  = '{ld: 12'd50, st: 12'd41, exp_ld: 7'd2, exp_st: 7'd2, exp_next: 7'd4};
    vecs[6]  = '{ld: 12'd31, st: 12'd60, exp_ld: 7'd1, exp_st: 7'd1, exp_next: 7'd4};
    vecs[7]  = '{ld: 12'd30, st: 12'd31, exp_ld: 7'd1, exp_st: 7'd1, exp_next: 7'd4};
    vecs[8]  = '{ld: 12'd70, st: 12'd70, exp_ld: 7'd4, exp_st: 7'd4, exp_next: 7'd5};
    vecs[9]  = '{ld: 12'd20, st: 12'd11, exp_ld: 7'd0, exp_st: 7'd0, exp_next: 7'd5};
    vecs[10] = '{ld: 12'd11, st: 12'd10, exp_ld: 7'd0, exp_st: 7'd0, exp_next: 7'd5};

    $display("[TB] start");
    doReset();

    // Reset state, all ports looking at index 5.
    for (int k = 0; k < NRD; k++) setPort(k, 12'd5);
    #1;
    for (int k = 0; k < NRD; k++) begin
      checkVal("rst_valid", int'(rd_valid_out[k]), 0);
      checkVal("rst_ssid", portSsid(k), 0);
    end
    checkVal("rst_ready", int'(update_ready_out), 1);
    checkVal("rst_busy", int'(busy_out), 0);
    checkVal("rst_next", int'(next_ssid_out), 0);

`ifdef SSIT_CYCLIC_CLEAR_EN
    // Automatic sweep after PERIOD cycles, then reset in the middle of it.
    applyStimulus(12'd10, 12'd20);
    checkVal("cyc_alloc_valid", int'(rd_valid_out[0]), 1);
    while (!busy_out && cyc < 400) begin
      @(posedge clock);
      #1;
    end
    checkVal("cyc_busy_rise", int'(busy_out), 1);
    checkVal("cyc_start_cycle", cyc, PERIOD + 1);
    repeat (5) @(posedge clock);
    #1 checkVal("cyc_busy_mid", int'(busy_out), 1);
    reset = 1'b1;
    #1;
    checkVal("cyc_rst_busy", int'(busy_out), 0);
    checkVal("cyc_rst_ready", int'(update_ready_out), 1);
    checkVal("cyc_rst_valid_ld", int'(rd_valid_out[0]), 0);
    checkVal("cyc_rst_valid_st", int'(rd_valid_out[1]), 0);
    checkVal("cyc_rst_next", int'(next_ssid_out), 0);
    @(negedge clock);
    reset = 1'b0;
`else
    // First allocation: ready must drop for exactly one cycle.
    applyStimulus(12'd10, 12'd20);
    checkOutput("first_alloc", '{ld: 12'd10, st: 12'd20, exp_ld: 7'd0, exp_st: 7'd0, exp_next: 7'd1});

    // Merge table from a fresh reset. Port 2 watches an untouched entry.
    doReset();
    setPort(2, 12'd99);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].ld, vecs[i].st);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
      checkVal($sformatf("vec%0d_untouched", i), int'(rd_valid_out[2]), 0);
    end

    // Allocator wrap: 128 allocations, then a 129th reuses SSID 0.
    doReset();
    for (int i = 0; i < 128; i++) begin
      applyStimulus(IW'(1000 + 2*i), IW'(1001 + 2*i));
      checkVal($sformatf("wrap%0d_ssid", i), portSsid(0), i);
      checkVal($sformatf("wrap%0d_next", i), int'(next_ssid_out), (i + 1) % 128);
    end
    applyStimulus(12'd2000, 12'd2001);
    checkOutput("wrap_129th", '{ld: 12'd2000, st: 12'd2001, exp_ld: 7'd0, exp_st: 7'd0, exp_next: 7'd1});

    // Flush while an update is held; a second flush mid-sweep is absorbed.
    @(negedge clock);
    update_ld_index_in = 12'd3000;
    update_st_index_in = 12'd3001;
    update_v_in = 1'b1;
    flush_in = 1'b1;
    setPort(0, 12'd1000);
    setPort(1, 12'd2000);
    setPort(2, 12'd1255);
    setPort(3, 12'd2001);
    #1 checkVal("flush_ready_low", int'(update_ready_out), 0);
    @(posedge clock);
    #1 flush_in = 1'b0;
    busy_cnt = 0;
    while (busy_out && busy_cnt < 200) begin
      busy_cnt++;
      flush_in = (busy_cnt == 10);
      @(posedge clock);
      #1;
    end
    flush_in = 1'b0;
    checkVal("flush_busy_cycles", busy_cnt, DEPTH / CPC);
    checkVal("flush_ready_after", int'(update_ready_out), 1);
    for (int k = 0; k < NRD; k++)
      checkVal($sformatf("flush_cleared%0d", k), int'(rd_valid_out[k]), 0);
    checkVal("flush_ssid_kept", portSsid(1), 0);
    checkVal("flush_next_kept", int'(next_ssid_out), 1);
    @(posedge clock);
    #1 checkVal("flush_update_accepted", int'(update_ready_out), 0);
    update_v_in = 1'b0;
    setPort(0, 12'd3000);
    setPort(1, 12'd3001);
    @(posedge clock);
    #1 checkOutput("post_flush", '{ld: 12'd3000, st: 12'd3001, exp_ld: 7'd1, exp_st: 7'd1, exp_next: 7'd2});
    checkVal("no_second_sweep", int'(busy_out), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssit_mp.md
Name: ssit_mp

Overview:
- Parametrised store set ID table for memory dependence prediction in the rename stage.
- Provides NUM_RD combinational lookup ports that return an SSID and a valid bit per PC index.
- Accepts load/store violation pairs through a valid/ready handshake and applies them with a two-stage read-then-merge update.
- Adds a periodic/forced cyclic clear that sweeps the table invalidating entries, so stale store sets age out.

Parameters:
- SSIT_DEPTH, 4096, number of table entries (power of two).
- INDEX_W, 12, index width, log2(SSIT_DEPTH).
- SSID_W, 7, store set ID width.
- NUM_RD, 4, number of lookup ports.
- CLEAR_PERIOD, 65536, cycles between automatic sweeps (only with SSIT_CYCLIC_CLEAR_EN).
- CLEAR_PER_CYCLE, 64, entries invalidated per sweep cycle (divides SSIT_DEPTH).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_index_in  in  NUM_RD*INDEX_W  lookup indices; port k occupies bits [k*INDEX_W +: INDEX_W].
- rd_ssid_out  out  NUM_RD*SSID_W  SSID per port, same packing.
- rd_valid_out  out  NUM_RD  entry valid per port.
- update_v_in  in  1  violation pair offered.
- update_ready_out  out  1  update accepted this cycle when update_v_in is high.
- update_ld_index_in  in  INDEX_W  load PC index.
- update_st_index_in  in  INDEX_W  store PC index.
- flush_in  in  1  request an immediate full sweep.
- busy_out  out  1  sweep in progress.
- next_ssid_out  out  SSID_W  next SSID to be allocated.

Behaviour:
- Reset (async, high):
  - All valid bits 0; all SSIDs 0; next_ssid 0; period counter 0; sweep pointer 0; state IDLE.
  - Outputs: rd_valid_out 0, rd_ssid_out 0, update_ready_out 1, busy_out 0.
  - Reset asserted mid-update or mid-sweep aborts it; the state restarts at IDLE.
- Lookups: purely combinational from the array; no bypass of in-flight updates.
- FSM states: IDLE, MERGE, SWEEP.
- update_ready_out is high only in IDLE with no pending flush or timer expiry.
- IDLE:
  - On update_v_in && ready, capture both indices and their current SSIDs and valid bits; go to MERGE.
  - Otherwise, if flush_in or a sweep request is pending, go to SWEEP.
- MERGE (one cycle); returns to IDLE, with captured valid bits {ld,st}:
  - 00: write next_ssid to both entries and set both valid; next_ssid increments modulo 2^SSID_W (wraps 2^SSID_W-1 to 0).
  - 01: ld entry takes st SSID and is set valid.
  - 10: st entry takes ld SSID and is set valid.
  - 11: the larger-SSID entry takes the smaller SSID; on equal SSIDs, no write.
  - ld index equal to st index: case 00 allocates once and writes that entry valid; the other cases are a harmless self-write.
- Update visibility: accepted at edge N, written at edge N+1, visible on lookups from cycle N+1 after that edge.
- SWEEP:
  - Each cycle, clear valid for entries [ptr, ptr+CLEAR_PER_CYCLE-1]; ptr advances by CLEAR_PER_CYCLE.
  - After SSIT_DEPTH/CLEAR_PER_CYCLE cycles, ptr wraps to 0 and the state returns to IDLE.
  - busy_out is high throughout; SSID values and next_ssid are unchanged.
- flush_in is sticky until the sweep begins.
- flush_in asserted during SWEEP is absorbed into the current sweep; no second sweep.
- Simultaneous update and flush in IDLE: the update is refused (ready is low while the flush is pending), and the sweep runs first.

Optional Feature:
- Macro: SSIT_CYCLIC_CLEAR_EN.
- Defined:
  - A free-running counter counts 0..CLEAR_PERIOD-1 in every state.
  - On reaching CLEAR_PERIOD-1 it wraps to 0 and raises a sticky sweep request, handled like flush_in.
  - An expiry arriving during an active sweep is absorbed.
- Undefined: no counter logic; sweeps occur only via flush_in.

Test Plan:
- Reset then lookup index 5 on all ports -> valid 0, ssid 0, ready 1, next_ssid_out 0.
- Update ld=10, st=20, both invalid -> two cycles later entries 10 and 20 read ssid 0, valid 1; next_ssid_out 1; ready low for exactly one cycle.
- Entry 10 holds ssid 3 and entry 30 holds ssid 1; update ld=10, st=30 -> entry 10 reads 1, entry 30 stays 1.
- 128 allocations with distinct indices -> next_ssid_out wraps from 127 to 0; the 129th allocation writes ssid 0.
- flush_in pulsed while update_v_in is held with SSIT_DEPTH=4096 and CLEAR_PER_CYCLE=64 -> busy high for 64 cycles, all valid bits 0 afterwards, next_ssid unchanged, update accepted the cycle after busy falls.
- With SSIT_CYCLIC_CLEAR_EN defined and CLEAR_PERIOD=256 -> a sweep starts automatically after 256 cycles; assert reset mid-sweep -> busy 0 immediately and all entries invalid.
